// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder with a small controlling FSM. One operation computes
// a + b + cin, one bit per clock, LSB first. The datapath is a single 1-bit
// cell made of two half adders and a carry register.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request a new addition (accepted when the FSM is ready)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed (WIDTH cycles)
//   done   out  one-cycle pulse when sum/carry hold a new result
//   sum    out  registered WIDTH-bit result
//   carry  out  registered carry-out of the MSB
//   ovf    out  registered signed overflow (only with SERIAL_ADD_OVF_EN)
//
// Configuration
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf port and its logic.
//
// Timing for an accept on edge E0: bits are processed on edges E0+1..E0+WIDTH.
// The last of these loads sum/carry and enters DONE. The edge that leaves
// DONE (E0+WIDTH+1) is also the earliest edge that can accept a new start.
// This gives back-to-back operations a period of WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  // One-bit cell: the first half adder combines the operand bits, and the
  // second one folds in the running carry.
  logic ha1_s, ha1_c, ha2_c, bit_s, c_next;

  assign ha1_s  = a_sh[0] ^ b_sh[0];
  assign ha1_c  = a_sh[0] & b_sh[0];
  assign bit_s  = ha1_s ^ c_reg;
  assign ha2_c  = ha1_s & c_reg;
  assign c_next = ha1_c | ha2_c;

  // Controller and datapath registers. The partial sum fills from the MSB
  // side. After WIDTH shifts it is aligned, so the final bit is merged
  // directly into sum on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance. This means its exit edge
        // can start the next operation immediately.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          psum  <= {bit_s, psum[WIDTH-1:1]};
          c_reg <= c_next;
          if (cnt == CNT_LAST) begin
            // On the MSB step, c_reg is the carry into the MSB.
            sum   <= {bit_s, psum[WIDTH-1:1]};
            carry <= c_next;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= c_reg ^ c_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl at WIDTH=8. Inputs are driven and
// outputs are sampled on the falling edge. Expected results come from plain
// integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: this is a full-width arithmetic add.
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow occurs when both operands have the same sign and the
  // result sign differs from it.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Drives one operation. The caller is at a falling edge, and this edge
  // comes right before the accepting edge E0. After E0, the inputs are
  // scrambled. The sample taken at index k follows edge E0+k. Optional
  // injections are supported:
  //   repulse_at - start pulse with a=0x01, seen at edge E0+repulse_at
  //   rst_at     - reset, seen at edge E0+rst_at
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input int repulse_at, input int rst_at,
                        output int busy_cnt, output int done_at, output int done_cnt,
                        output int both_hi, output int early_chg,
                        output logic [W-1:0] s_out, output logic c_out, output logic o_out,
                        output logic busy_rst, output logic [W-1:0] sum_rst);
    logic [W-1:0] sum_before;
    busy_cnt  = 0;
    done_at   = -1;
    done_cnt  = 0;
    both_hi   = 0;
    early_chg = 0;
    s_out     = 'x;
    c_out     = 1'bx;
    o_out     = 1'bx;
    busy_rst  = 1'bx;
    sum_rst   = 'x;
    sum_before = sum;
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_cnt++;
      if (busy && done) both_hi++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          s_out   = sum;
          c_out   = carry;
`ifdef SERIAL_ADD_OVF_EN
          o_out   = ovf;
`else
          o_out   = 1'b0;
`endif
        end
      end
      if (rst_at < 0 && done_at < 0 && sum !== sum_before) early_chg++;
      if (k == rst_at) begin
        busy_rst = busy;
        sum_rst  = sum;
        rst      = 1'b0;
      end
      if (k == rst_at - 1) rst = 1'b1;
      if (k == repulse_at) start = 1'b0;
      if (k == repulse_at - 1) begin
        start = 1'b1;
        a     = 8'h01;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // This task applies reset while start is high, so reset must win. It then
  // checks that outputs clear and that no operation begins.
  task automatic test_reset();
    int busy_seen;
    int done_seen;
    busy_seen = 0;
    done_seen = 0;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h0F;
    b     = 8'h01;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done got %b want 0", done);
    end
    vectors++;
    if (sum !== 8'h00 || carry !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_result got sum=%h carry=%b want 00/0", sum, carry);
    end
`ifdef SERIAL_ADD_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    vectors++;
    if (busy_seen != 0 || done_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_beats_start got busy_cycles=%0d done_cycles=%0d want 0/0",
               busy_seen, done_seen);
    end
  endtask

  // This task handles the directed cases and the random cases. It checks the
  // full result, busy length, done timing, and the rule that sum stays put
  // until completion.
  task automatic test_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input string name);
    int bc, da, dc, bh, ec;
    logic [W-1:0] s, sr;
    logic c, o, br;
    logic [W:0] exp;
    exp = model_add(ta, tb_v, tcin);
    run_op(ta, tb_v, tcin, -1, -1, bc, da, dc, bh, ec, s, c, o, br, sr);
    vectors++;
    if (s !== exp[W-1:0] || c !== exp[W]) begin
      miscompares++;
      $display("[TB] FAIL %s_result a=%h b=%h cin=%b got sum=%h carry=%b want sum=%h carry=%b",
               name, ta, tb_v, tcin, s, c, exp[W-1:0], exp[W]);
    end
`ifdef SERIAL_ADD_OVF_EN
    vectors++;
    if (o !== model_ovf(ta, tb_v, exp[W-1:0])) begin
      miscompares++;
      $display("[TB] FAIL %s_ovf a=%h b=%h got %b want %b", name, ta, tb_v, o,
               model_ovf(ta, tb_v, exp[W-1:0]));
    end
`endif
    vectors++;
    if (bc != W || da != W || dc != 1) begin
      miscompares++;
      $display("[TB] FAIL %s_timing got busy_cycles=%0d done_at=%0d done_count=%0d want %0d/%0d/1",
               name, bc, da, dc, W, W);
    end
    vectors++;
    if (bh != 0 || ec != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_overlap got busy_and_done=%0d early_sum_changes=%0d want 0/0",
               name, bh, ec);
    end
  endtask

  // This task sends a start re-pulse in the middle of an operation. The pulse
  // must be ignored, so exactly one done appears with the original result.
  task automatic test_restart_ignored();
    int bc, da, dc, bh, ec;
    logic [W-1:0] s, sr;
    logic c, o, br;
    run_op(8'h0F, 8'h01, 1'b0, 3, -1, bc, da, dc, bh, ec, s, c, o, br, sr);
    vectors++;
    if (dc != 1 || da != W || s !== 8'h10 || c !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_ignored got done_count=%0d done_at=%0d sum=%h carry=%b want 1/%0d/10/0",
               dc, da, s, c, W);
    end
    vectors++;
    if (bc != W) begin
      miscompares++;
      $display("[TB] FAIL restart_busy got %0d want %0d", bc, W);
    end
  endtask

  // This task applies reset in the middle of a run. The partial result is
  // dropped and there is no done pulse. A fresh add must then work normally.
  task automatic test_reset_mid_run();
    int bc, da, dc, bh, ec;
    logic [W-1:0] s, sr;
    logic c, o, br;
    run_op(8'h0F, 8'h01, 1'b0, -1, 4, bc, da, dc, bh, ec, s, c, o, br, sr);
    vectors++;
    if (br !== 1'b0 || sr !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset got busy=%b sum=%h want 0/00", br, sr);
    end
    vectors++;
    if (dc != 0) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_done got done_count=%0d want 0", dc);
    end
    test_add(8'h55, 8'hAA, 1'b1, "after_reset");
  endtask

  // This task holds start high. Operations must chain with a W+1 cycle
  // period, and each one must give the same result.
  task automatic test_back_to_back();
    int pulses[$];
    int bh;
    int bad_sum;
    bh = 0;
    bad_sum = 0;
    a     = 8'h0F;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        pulses.push_back(k);
        if (sum !== 8'h10 || carry !== 1'b0) bad_sum++;
      end
      if (busy && done) bh++;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (pulses.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got %0d pulses want 3", pulses.size());
    end else begin
      vectors++;
      if (pulses[0] != W || pulses[1] - pulses[0] != W + 1 || pulses[2] - pulses[1] != W + 1) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing got %0d,%0d,%0d want %0d,%0d,%0d",
                 pulses[0], pulses[1], pulses[2], W, 2 * W + 1, 3 * W + 2);
      end
    end
    vectors++;
    if (bh != 0 || bad_sum != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_result got busy_and_done=%0d bad_sums=%0d want 0/0", bh, bad_sum);
    end
  endtask

  // This task runs random operand sweeps and compares them with the
  // arithmetic model.
  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_add(W'($urandom), W'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    @(negedge clk);
    test_reset();
    test_add(8'h0F, 8'h01, 1'b0, "add_0f_01");
    test_add(8'hFF, 8'h01, 1'b0, "add_ff_01");
    test_add(8'h7F, 8'h01, 1'b0, "add_7f_01");
    test_add(8'h80, 8'h80, 1'b1, "add_80_80");
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
